ifu: RTL



---
 rtl/ifu_pkg.sv | 22 ++
 rtl/ifu.sv | 116 +++++++++++
 2 files changed

// File: rtl/ifu_pkg.sv
// Shared widths, reset PC and FSM encodings for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] CPU_RESET_PC = 32'h8000_0000;

  // Two-bit state encoding shared with anything that inspects the fetch FSM.
  typedef enum logic [1:0] {
    IFU_S_IDLE = 2'd0,
    IFU_S_REQ  = 2'd1,
    IFU_S_WAIT = 2'd2,
    IFU_S_HOLD = 2'd3
  } ifu_state_e;

  // Instructions are word aligned; the low two address bits are forced to zero.
  function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] pc);
    return pc & ~(CPU_WIDTH'(3));
  endfunction

endpackage

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps at most one imem fetch in flight,
// buffers the returned word and hands {pc, inst} to decode over valid/ready.
// A redirect retargets the PC in any state; a fetch it makes stale is dropped.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_redirect,
  input  logic [CPU_WIDTH-1:0] i_redirect_pc,
  output logic                 o_imem_req,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_gnt,
  input  logic                 i_imem_rvalid,
  input  logic [INS_WIDTH-1:0] i_imem_rdata,
  output logic                 o_ifu_valid,
  output logic [CPU_WIDTH-1:0] o_ifu_pc,
  output logic [INS_WIDTH-1:0] o_ifu_inst,
  input  logic                 i_idu_ready
);

  localparam logic [CPU_WIDTH-1:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

  ifu_state_e           state_q,  state_d;
  logic [CPU_WIDTH-1:0] pc_q,     pc_d;
  logic                 drop_q,   drop_d;
  logic [INS_WIDTH-1:0] inst_q,   inst_d;
  logic [CPU_WIDTH-1:0] ifu_pc_q, ifu_pc_d;

  // Next-state logic: FSM transitions, PC update, stale-fetch tracking, buffer load.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    inst_d   = inst_q;
    ifu_pc_d = ifu_pc_q;

    unique case (state_q)
      IFU_S_IDLE: begin
        state_d = IFU_S_REQ;
      end

      IFU_S_REQ: begin
        if (i_imem_gnt) begin
          state_d = IFU_S_WAIT;
          // The accepted request still targets the old PC, so its answer is stale.
          if (i_redirect) drop_d = 1'b1;
        end
      end

      IFU_S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop_q || i_redirect) begin
            // Stale response: throw it away and fetch again from the current PC.
            drop_d  = 1'b0;
            state_d = IFU_S_REQ;
          end else begin
            inst_d   = i_imem_rdata;
            ifu_pc_d = pc_q;
            state_d  = IFU_S_HOLD;
          end
        end else if (i_redirect) begin
          drop_d = 1'b1;
        end
      end

      IFU_S_HOLD: begin
        if (i_idu_ready) begin
          pc_d    = pc_q + CPU_WIDTH'(4);
          state_d = IFU_S_REQ;
        end else if (i_redirect) begin
          // Buffered instruction is on the wrong path; discard it unconsumed.
          state_d = IFU_S_REQ;
        end
      end

      default: begin
        state_d = IFU_S_IDLE;
      end
    endcase

    // Redirect wins over the sequential pc+4 update in every state.
    if (i_redirect) pc_d = align_pc(i_redirect_pc);
  end

  // State, PC, drop flag and instruction buffer, all asynchronously reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IFU_S_IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      drop_q   <= 1'b0;
      inst_q   <= '0;
      ifu_pc_q <= RESET_PC_ALIGNED;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      inst_q   <= inst_d;
      ifu_pc_q <= ifu_pc_d;
    end
  end

  // Outputs decode from registered state only, so ready/redirect never reach them combinationally.
  assign o_imem_req  = (state_q == IFU_S_REQ);
  assign o_imem_addr = pc_q;
  assign o_ifu_valid = (state_q == IFU_S_HOLD);
  assign o_ifu_pc    = ifu_pc_q;
  assign o_ifu_inst  = inst_q;

endmodule
